// File: rtl/uop_selftest_pkg.sv
// Shared types and sizing helpers for the gate self-test sequencer.
package uop_selftest_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   localparam int unsigned N_IN_MAX = 6;

   // Number of input minterms for an n-input gate.
   function automatic int unsigned minterm_cnt(input int unsigned n);
      return 32'(1) << n;
   endfunction

   // Bits needed to count 0..v-1 (at least one).
   function automatic int unsigned cnt_width(input int unsigned v);
      return (v < 2) ? 1 : 32'($clog2(v));
   endfunction

endpackage

// File: rtl/uop_minterm_seq_if.sv
// Control/result bundle between board logic, gate under test and the sequencer.
interface uop_minterm_seq_if #(
   parameter int unsigned N_IN = 2
);
   logic            start;
   logic [N_IN-1:0] dut_in;
   logic            dut_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   fail_count;
   logic [N_IN-1:0] first_fail;

   modport master (
      output start, dut_out,
      input  dut_in, busy, done, pass, fail_count, first_fail
   );

   modport slave (
      input  start, dut_out,
      output dut_in, busy, done, pass, fail_count, first_fail
   );
endinterface

// File: rtl/uop_settle_timer.sv
// Settle-time counter: counts enabled cycles and flags the last settle cycle.
module uop_settle_timer
   import uop_selftest_pkg::*;
#(
   parameter int unsigned SETTLE = 2
) (
   input  logic clk,
   input  logic n_reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned    CW   = cnt_width(SETTLE);
   localparam logic [CW-1:0]  LAST = CW'(SETTLE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && !expired)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uop_minterm_seq.sv
// Walks every minterm onto a combinational gate and checks it against EXPECT.
// Optional UOP_SEQ_STOP_ON_FAIL_EN ends the run at the first mismatch.
module uop_minterm_seq
   import uop_selftest_pkg::*;
#(
   parameter int unsigned              N_IN   = 2,
   parameter logic [(1 << N_IN)-1:0]   EXPECT = 4'b1001,
   parameter int unsigned              SETTLE = 2
) (
   input logic              clk,
   input logic              n_reset,
   uop_minterm_seq_if.slave bus
);
   localparam int unsigned     N_MINT = minterm_cnt(N_IN);
   localparam logic [N_IN-1:0] LAST   = N_IN'(N_MINT - 1);

   seq_state_e      state_q, state_d;
   logic [N_IN-1:0] minterm_q, minterm_d;
   logic [N_IN:0]   fail_count_q, fail_count_d;
   logic [N_IN-1:0] first_fail_q, first_fail_d;
   logic            pass_q, pass_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            expired;
   logic            mismatch_c;

   // Counter sits at zero outside WAIT so each minterm starts a fresh settle.
   uop_settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk     (clk),
      .n_reset (n_reset),
      .clear   (state_q != ST_WAIT),
      .enable  (state_q == ST_WAIT),
      .expired (expired)
   );

   assign mismatch_c = (bus.dut_out != EXPECT[minterm_q]);

   always_comb begin
      state_d      = state_q;
      minterm_d    = minterm_q;
      fail_count_d = fail_count_q;
      first_fail_d = first_fail_q;
      pass_d       = pass_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d      = ST_WAIT;
               minterm_d    = '0;
               fail_count_d = '0;
               first_fail_d = '0;
               pass_d       = 1'b0;
            end
         end
         ST_WAIT: begin
            if (expired) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (mismatch_c) begin
               fail_count_d = fail_count_q + (N_IN+1)'(1);
               if (fail_count_q == '0) first_fail_d = minterm_q;
            end
`ifdef UOP_SEQ_STOP_ON_FAIL_EN
            if (mismatch_c || (minterm_q == LAST)) begin
`else
            if (minterm_q == LAST) begin
`endif
               state_d = ST_DONE;
            end else begin
               minterm_d = minterm_q + N_IN'(1);
               state_d   = ST_WAIT;
            end
         end
         ST_DONE: begin
            pass_d    = (fail_count_q == '0);
            minterm_d = '0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_WAIT) || (state_d == ST_CHECK);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q      <= ST_IDLE;
         minterm_q    <= '0;
         fail_count_q <= '0;
         first_fail_q <= '0;
         pass_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         minterm_q    <= minterm_d;
         fail_count_q <= fail_count_d;
         first_fail_q <= first_fail_d;
         pass_q       <= pass_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.dut_in     = minterm_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.fail_count = fail_count_q;
   assign bus.first_fail = first_fail_q;
endmodule

// File: tb/tb_uop_minterm_seq.sv
// Directed bench: default 2-input XNOR sequencer and a 3-input XOR, SETTLE=1 one.
module tb_uop_minterm_seq;
   localparam int unsigned M_XNOR  = 0;
   localparam int unsigned M_XOR   = 1;
   localparam int unsigned M_STUCK = 2;

   typedef struct {
      int unsigned sel;
      int unsigned mode;
      int unsigned done_k;
      int unsigned fc;
      int unsigned ff;
      int unsigned pass;
      bit          seq;
   } vec_t;

   logic clk = 1'b0;
   logic n_reset = 1'b0;
   int unsigned mode = M_XNOR;
   int unsigned sel = 0;
   int n_tests = 0;
   int n_fail = 0;
   vec_t vecs [6];

   uop_minterm_seq_if #(.N_IN(2)) bus1 ();
   uop_minterm_seq_if #(.N_IN(3)) bus2 ();

   uop_minterm_seq dut1 (.clk(clk), .n_reset(n_reset), .bus(bus1.slave));
   uop_minterm_seq #(.N_IN(3), .EXPECT(8'h96), .SETTLE(1))
      dut2 (.clk(clk), .n_reset(n_reset), .bus(bus2.slave));

   always #5 clk = ~clk;

   // Gate models for each sequencer.
   always_comb begin
      case (mode)
         M_XOR:   bus1.dut_out = ^bus1.dut_in;
         M_STUCK: bus1.dut_out = (bus1.dut_in == 2'd2) ? 1'b1 : ~(^bus1.dut_in);
         default: bus1.dut_out = ~(^bus1.dut_in);
      endcase
   end
   always_comb bus2.dut_out = (mode == M_XOR) ? ^bus2.dut_in : ~(^bus2.dut_in);

   logic       cur_done, cur_busy, cur_pass;
   logic [7:0] cur_dut_in, cur_fc, cur_ff;
   assign cur_done   = (sel != 0) ? bus2.done : bus1.done;
   assign cur_busy   = (sel != 0) ? bus2.busy : bus1.busy;
   assign cur_pass   = (sel != 0) ? bus2.pass : bus1.pass;
   assign cur_dut_in = (sel != 0) ? 8'(bus2.dut_in) : 8'(bus1.dut_in);
   assign cur_fc     = (sel != 0) ? 8'(bus2.fail_count) : 8'(bus1.fail_count);
   assign cur_ff     = (sel != 0) ? 8'(bus2.first_fail) : 8'(bus1.first_fail);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel != 0) bus2.start = v;
      else          bus1.start = v;
   endtask

   // Pulse start; leaves the caller sampling #1 after edge E0 (k = 0).
   task automatic pulse_start();
      @(negedge clk);
      set_start(1'b1);
      @(posedge clk);
      #1;
      set_start(1'b0);
   endtask

   task automatic run_vec(input vec_t v);
      int unsigned done_k = 999;
      int seq_err = 0;
      bit seen = 0;
      sel  = v.sel;
      mode = v.mode;
      pulse_start();
      for (int k = 0; k < 80 && !seen; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         if (cur_done) begin
            seen   = 1;
            done_k = 32'(k);
         end else begin
            if (!cur_busy || cur_pass) seq_err++;
            if (v.seq && cur_dut_in != 8'(k / 3)) seq_err++;
         end
      end
      check("done_edge", done_k, v.done_k);
      check("run_seq_errors", seq_err, 0);
      check("busy_in_done", 32'(cur_busy), 0);
      check("fail_count", 32'(cur_fc), v.fc);
      check("first_fail", 32'(cur_ff), v.ff);
      @(posedge clk);
      #1;
      check("pass", 32'(cur_pass), v.pass);
      check("done_one_cycle", 32'(cur_done), 0);
      check("dut_in_idle", 32'(cur_dut_in), 0);
   endtask

   initial begin
      int dones;
      int unsigned dk;
      bus1.start = 1'b0;
      bus2.start = 1'b0;

      vecs[0] = '{0, M_XNOR, 12, 0, 0, 1, 1};
`ifdef UOP_SEQ_STOP_ON_FAIL_EN
      vecs[1] = '{0, M_XOR,   3, 1, 0, 0, 0};
      vecs[2] = '{0, M_STUCK, 9, 1, 2, 0, 0};
      vecs[5] = '{1, M_XNOR,  2, 1, 0, 0, 0};
`else
      vecs[1] = '{0, M_XOR,  12, 4, 0, 0, 1};
      vecs[2] = '{0, M_STUCK, 12, 1, 2, 0, 1};
      vecs[5] = '{1, M_XNOR, 16, 8, 0, 0, 0};
`endif
      vecs[3] = '{0, M_XNOR, 12, 0, 0, 1, 1};
      vecs[4] = '{1, M_XOR,  16, 0, 0, 1, 0};

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus1.busy), 0);
      check("rst_done", 32'(bus1.done), 0);
      check("rst_pass", 32'(bus1.pass), 0);
      check("rst_fc", 32'(bus1.fail_count), 0);
      check("rst_ff", 32'(bus1.first_fail), 0);
      check("rst_dut_in", 32'(bus1.dut_in), 0);
      @(negedge clk);
      n_reset = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Second start while busy must be ignored.
      sel = 0;
      mode = M_XNOR;
      dones = 0;
      dk = 999;
      pulse_start();
      for (int k = 0; k < 30; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         bus1.start = (k == 4);
         if (bus1.done) begin
            dones++;
            dk = 32'(k);
         end
      end
      bus1.start = 1'b0;
      check("busy_start_dones", dones, 1);
      check("busy_start_done_edge", dk, 12);
      check("busy_start_pass", 32'(bus1.pass), 1);
      check("busy_start_fc", 32'(bus1.fail_count), 0);

      // Reset asserted during WAIT of minterm 2 with failures accumulated.
      mode = M_XOR;
      pulse_start();
      repeat (6) @(posedge clk);
      #1;
      check("pre_rst_dut_in", 32'(bus1.dut_in),
`ifdef UOP_SEQ_STOP_ON_FAIL_EN
            0);
`else
            2);
`endif
      @(negedge clk);
      n_reset = 1'b0;
      #1;
      check("mid_rst_busy", 32'(bus1.busy), 0);
      check("mid_rst_fc", 32'(bus1.fail_count), 0);
      check("mid_rst_ff", 32'(bus1.first_fail), 0);
      check("mid_rst_dut_in", 32'(bus1.dut_in), 0);
      check("mid_rst_pass_done", {30'd0, bus1.pass, bus1.done}, 0);
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uop_minterm_seq.md
# uop_minterm_seq

Self-test sequencer for a combinational gate block with `N_IN` inputs, such as the `uop_nxor` gate. After a `start` pulse it walks every input minterm onto the gate, waits a programmable settle time, and samples the gate output. It checks each sample against a truth-table parameter and reports the pass/fail count and the first failing minterm. It is the synthesizable, on-chip counterpart of the gate test benches, and sits between the board control logic and the gate under test.

## Interface
Parameters:
- `N_IN`, 2, number of gate inputs (1..6).
- `EXPECT`, 4'b1001, truth table of width 2^N_IN; bit k is the expected output for minterm k. The default is XNOR.
- `SETTLE`, 2, number of wait cycles between driving a minterm and sampling it (≥1).

Ports:
- `clk` input 1: single clock, rising edge.
- `n_reset` input 1: asynchronous, active-low reset.
- `start` input 1: requests a run; sampled only in IDLE.
- `dut_in` output N_IN: minterm driven to the gate; MSB goes to the first gate input.
- `dut_out` input 1: gate output.
- `busy` output 1: high in WAIT and CHECK.
- `done` output 1: one-cycle pulse at the end of a run.
- `pass` output 1: high after a run completes with zero failures; held until the next `start`.
- `fail_count` output N_IN+1: number of mismatching minterms in the last run.
- `first_fail` output N_IN: lowest failing minterm; valid when `fail_count`≠0.

## Operation
- The FSM has four states: IDLE, WAIT, CHECK, DONE.
- IDLE, with `start`=1:
  - Next state is WAIT.
  - Clear the minterm, the settle counter, `fail_count`, `first_fail` and `pass`.
- WAIT:
  - The settle counter increments each cycle.
  - When the count reaches SETTLE-1, next state is CHECK.
  - `dut_in` is held at the current minterm throughout.
- CHECK lasts one cycle:
  - Compare `dut_out` with `EXPECT[minterm]`.
  - On mismatch, `fail_count`++. If this is the first failure, latch `first_fail`=minterm.
  - If minterm = 2^N_IN−1, next state is DONE.
  - Otherwise increment the minterm, clear the counter, and go to WAIT.
- DONE lasts one cycle:
  - `done`=1.
  - `pass`<=(`fail_count`==0).
  - Next state is IDLE.
- In IDLE, `dut_in` drives 0.
- `start` is ignored outside IDLE and never queues.
- Reset values, including reset asserted mid-run: state IDLE, `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail`=0. There is no partial-run reporting.
- `fail_count` is N_IN+1 bits wide, so it can hold 2^N_IN without wrapping.
- The minterm counter never wraps within a run. The terminal minterm always exits to DONE.

## Timing
- Each minterm takes SETTLE+1 cycles.
- Let edge E0 be the edge that samples `start`.
- The DONE state, and therefore `done`=1, occupies the cycle after edge E0 + 2^N_IN·(SETTLE+1).
  - For the defaults, that is edge E0+12.
- `busy` rises after E0 and falls when DONE is entered.
- Result outputs are registered:
  - `fail_count` and `first_fail` are stable from DONE onward.
  - `pass` becomes valid in the cycle after DONE.
- `start` held high continuously causes back-to-back runs, each separated by one IDLE cycle.

## Configuration
- Macro: `UOP_SEQ_STOP_ON_FAIL_EN`.
- Defined:
  - A mismatch in CHECK goes directly to DONE.
  - `fail_count` ≤ 1.
  - `first_fail` holds the failing minterm.
  - The run is shortened accordingly.
- Undefined: all 2^N_IN minterms are always checked, and `fail_count` gives the full total.

## Structure
- The shared package `uop_selftest_pkg` holds:
  - the state enum typedef;
  - `localparam` helpers for the minterm count (2^N_IN) and counter widths.
- One sub-module, `uop_settle_timer`:
  - Parameter SETTLE.
  - Inputs: `clear` and `enable`.
  - Output: `expired`.
  - Instantiated once, with the same clock and reset.

## Test plan
- Correct XNOR gate, defaults, `start` pulse at E0:
  - `dut_in` sequence is 0, 1, 2, 3, each held 3 cycles.
  - `done` at E0+12.
  - `pass`=1, `fail_count`=0.
- Gate replaced by XOR model:
  - `fail_count`=4, `first_fail`=0, `pass`=0.
  - With `UOP_SEQ_STOP_ON_FAIL_EN`: `fail_count`=1, and `done` at E0+3.
- Output stuck-at-1 on minterm 2 only:
  - `fail_count`=1, `first_fail`=2'b10.
- `start` pulsed again while `busy`:
  - Ignored; a single `done` pulse; results unchanged.
- `n_reset` asserted during WAIT of minterm 2:
  - All outputs 0 immediately.
  - After release, a new `start` gives a full clean run with `pass`=1.
- SETTLE=1, N_IN=3, EXPECT=8'h96 (3-input XOR):
  - `done` at E0+16.
  - `pass`=1.
